// File: rtl/fpu_addsub_arbiter_if.sv
// Requester, response and FP add/sub unit signals of the arbiter.
// slave = arbiter side, master = requesters plus unit side.
interface fpu_addsub_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;
  logic             req0_ready;
  logic             resp0_valid;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;
  logic             req1_ready;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp_result;
  logic             resp_err;
  logic             arb_busy;
  logic             fpu_start;
  logic [WIDTH-1:0] fpu_n1;
  logic [WIDTH-1:0] fpu_n2;
  logic             fpu_sel;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_done;
  logic             fpu_busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  fpu_result, fpu_done, fpu_busy,
    output req0_ready, resp0_valid,
    output req1_ready, resp1_valid,
    output resp_result, resp_err, arb_busy,
    output fpu_start, fpu_n1, fpu_n2, fpu_sel
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output fpu_result, fpu_done, fpu_busy,
    input  req0_ready, resp0_valid,
    input  req1_ready, resp1_valid,
    input  resp_result, resp_err, arb_busy,
    input  fpu_start, fpu_n1, fpu_n2, fpu_sel
  );
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP add/sub unit between two ports.
// Optional watchdog on ISSUE/RELEASE enabled by FPU_ARB_TIMEOUT_EN.
module fpu_addsub_arbiter #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 64,
  parameter bit PRIO_RESET = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  fpu_addsub_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    RELEASE
  } state_e;

  state_e           state_q;
  logic             last_q;
  logic             port_q;
  logic             start_q;
  logic             sel_q;
  logic             resp0_q;
  logic             resp1_q;
  logic [WIDTH-1:0] n1_q;
  logic [WIDTH-1:0] n2_q;
  logic [WIDTH-1:0] result_q;

  logic any_req;
  logic gnt1;
  logic accept;
  logic issue_end;
  logic release_end;

  assign any_req = bus.req0_valid | bus.req1_valid;
  // Tie goes to the port that was not served last.
  assign gnt1    = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign accept  = rst_n & (state_q == IDLE) & any_req;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          expired;

  assign expired     = (cnt_q == CNT_MAX);
  assign issue_end   = bus.fpu_done | expired;
  assign release_end = (~bus.fpu_done & ~bus.fpu_busy) | expired;
  assign bus.resp_err = err_q;
`else
  localparam int timeout_unused = TIMEOUT;

  assign issue_end   = bus.fpu_done;
  assign release_end = ~bus.fpu_done & ~bus.fpu_busy;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= PRIO_RESET;
      port_q   <= 1'b0;
      start_q  <= 1'b0;
      sel_q    <= 1'b0;
      resp0_q  <= 1'b0;
      resp1_q  <= 1'b0;
      n1_q     <= '0;
      n2_q     <= '0;
      result_q <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            port_q  <= gnt1;
            last_q  <= gnt1;
            n1_q    <= gnt1 ? bus.req1_a : bus.req0_a;
            n2_q    <= gnt1 ? bus.req1_b : bus.req0_b;
            sel_q   <= gnt1 ? bus.req1_op : bus.req0_op;
            start_q <= 1'b1;
            state_q <= ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ISSUE: begin
          if (issue_end) begin
            // An abort reports a zero result.
            result_q <= bus.fpu_done ? bus.fpu_result : '0;
            start_q  <= 1'b0;
            resp0_q  <= ~port_q;
            resp1_q  <= port_q;
            state_q  <= RESP;
`ifdef FPU_ARB_TIMEOUT_EN
            err_q    <= ~bus.fpu_done;
`endif
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        RESP: begin
          state_q <= RELEASE;
`ifdef FPU_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        RELEASE: begin
          if (release_end) begin
            state_q <= IDLE;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign bus.req0_ready  = accept & ~gnt1;
  assign bus.req1_ready  = accept & gnt1;
  assign bus.resp0_valid = resp0_q;
  assign bus.resp1_valid = resp1_q;
  assign bus.resp_result = result_q;
  assign bus.arb_busy    = (state_q != IDLE);
  assign bus.fpu_start   = start_q;
  assign bus.fpu_n1      = n1_q;
  assign bus.fpu_n2      = n2_q;
  assign bus.fpu_sel     = sel_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: unit BFM, scoreboard model, vectors, corners.
// Build with FPU_ARB_TIMEOUT_EN to also cover the watchdog abort.
module tb_fpu_addsub_arbiter;
  localparam int W = 32;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_addsub_arbiter_if #(.WIDTH(W)) bus();

  fpu_addsub_arbiter #(
    .WIDTH(W),
    .TIMEOUT(TO),
    .PRIO_RESET(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  // single-precision <-> real, normals and zero only
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input logic op);
    return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    return r2f(real'($urandom_range(0, 1000)));
  endfunction

  // unit BFM: done 6 cycles after start, parks while start held, 2-cycle drain
  int bs;
  bit hang = 1'b0;
  bit hold = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs <= 0;
      bus.fpu_done <= 1'b0;
      bus.fpu_busy <= 1'b0;
      bus.fpu_result <= '0;
    end else begin
      case (bs)
        0: if (bus.fpu_start) begin
          bs <= 1;
          bus.fpu_busy <= 1'b1;
        end
        1, 2, 3, 4: bs <= bs + 1;
        5: if (!hang) begin
          bs <= 6;
          bus.fpu_done <= 1'b1;
          bus.fpu_result <= fp(bus.fpu_n1, bus.fpu_n2, bus.fpu_sel);
        end
        6: if (!bus.fpu_start) begin
          bs <= 7;
          bus.fpu_done <= 1'b0;
        end
        7: bs <= 8;
        default: if (!hold) begin
          bs <= 0;
          bus.fpu_busy <= 1'b0;
        end
      endcase
    end
  end

  // scoreboard model: one op at a time, free 12 cycles after an accept
  typedef struct {
    bit          port;
    logic [31:0] res;
    bit          err;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t me;
  bit   mlast = 1'b0;
  int   last_acc = -100;
  bit   std_t = 1'b1;
  int   lat = 8;
  bit   g;
  bit   free_now;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mlast = 1'b0;
      last_acc = -100;
    end else begin
      free_now = (bus.req0_valid | bus.req1_valid) && q.size() == 0 &&
                 (cyc - last_acc) >= 12;
      if (std_t)
        chk("accept_when_free", bus.req0_ready | bus.req1_ready,
            free_now);
      if (bus.req0_ready | bus.req1_ready) begin
        g = bus.req1_valid && (!bus.req0_valid || !mlast);
        chk("grant_port", {bus.req1_ready, bus.req0_ready},
            g ? 2'b10 : 2'b01);
        me.port = g;
        me.t = cyc;
        me.err = hang;
        me.res = hang ? 32'd0 :
                 g ? fp(bus.req1_a, bus.req1_b, bus.req1_op)
                   : fp(bus.req0_a, bus.req0_b, bus.req0_op);
        q.push_back(me);
        mlast = g;
        last_acc = cyc;
      end
      if (bus.resp0_valid | bus.resp1_valid) begin
        if (q.size() == 0) begin
          chk("resp_expected", {bus.resp1_valid, bus.resp0_valid}, 2'b00);
        end else begin
          me = q.pop_front();
          chk("resp_port", {bus.resp1_valid, bus.resp0_valid},
              me.port ? 2'b10 : 2'b01);
          chk("resp_result", bus.resp_result, me.res);
          chk("resp_err", bus.resp_err, me.err);
          chk("resp_latency", cyc - me.t, lat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit v, input logic [31:0] a,
                       input logic [31:0] b, input bit op);
    if (port) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
  endtask

  task automatic drop();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_ready(input bit port, output int t);
    bit ok = 1'b0;
    t = cyc;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        t = cyc;
      end
    end
    if (!ok)
      chk("ready_timeout", port ? bus.req1_ready : bus.req0_ready, 1'b1);
  endtask

  task automatic wait_any(output bit port, output int t);
    bit ok = 1'b0;
    port = 1'b0;
    t = cyc;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.req0_ready | bus.req1_ready) begin
        ok = 1'b1;
        port = bus.req1_ready;
        t = cyc;
      end
    end
    if (!ok) chk("any_ready_timeout", bus.req0_ready | bus.req1_ready, 1);
  endtask

  task automatic wait_resp(input bit port, input int t0,
                           input logic [31:0] res, input int l,
                           input bit err);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.resp0_valid | bus.resp1_valid) begin
        ok = 1'b1;
        chk("seq_resp_port", {bus.resp1_valid, bus.resp0_valid},
            port ? 2'b10 : 2'b01);
        chk("seq_latency", cyc - t0, l);
        chk("seq_result", bus.resp_result, res);
        chk("seq_err", bus.resp_err, err);
      end
    end
    if (!ok) chk("resp_timeout", bus.resp0_valid | bus.resp1_valid, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!bus.arb_busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", bus.arb_busy, 1'b0);
  endtask

  task automatic run_one(input bit port, input logic [31:0] a,
                         input logic [31:0] b, input bit op,
                         input logic [31:0] res);
    int t0;
    step();
    drive(port, 1'b1, a, b, op);
    wait_ready(port, t0);
    step();
    drop();
    wait_resp(port, t0, res, 8, 1'b0);
    wait_idle();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {bus.req0_ready, bus.req1_ready, bus.resp0_valid,
               bus.resp1_valid, bus.resp_err, bus.arb_busy,
               bus.fpu_start, bus.fpu_sel}, 8'd0);
    chk({name, "_data"}, {bus.fpu_n1, bus.fpu_n2}, 64'd0);
    chk({name, "_result"}, bus.resp_result, 32'd0);
  endtask

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    bit          op;
    logic [31:0] res;
  } vec_t;

  vec_t vt[6];

  initial begin
    int  t0;
    int  tp;
    bit  p;

    vt[0] = '{1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vt[1] = '{1'b1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vt[2] = '{1'b0, 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000};
    vt[3] = '{1'b1, 32'h41200000, 32'h41200000, 1'b0, 32'h41A00000};
    vt[4] = '{1'b0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000};
    vt[5] = '{1'b1, 32'h40000000, 32'h40000000, 1'b1, 32'h00000000};

    drive(1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
    drive(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    step();
    drop();
    rst_n = 1'b1;

    // both ports valid from reset: grants 1,0,1,0 spaced 12 cycles
    step();
    drive(1'b0, 1'b1, 32'h40000000, 32'h3F800000, 1'b0);
    drive(1'b1, 1'b1, 32'h40A00000, 32'h3F800000, 1'b1);
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(p, t0);
      chk("rr_grant", p, (k % 2 == 0) ? 1'b1 : 1'b0);
      if (k > 0) chk("rr_spacing", t0 - tp, 12);
      tp = t0;
    end
    step();
    drop();
    wait_idle();

    for (int i = 0; i < 6; i++)
      run_one(vt[i].port, vt[i].a, vt[i].b, vt[i].op, vt[i].res);

    // operands held while the requester changes its inputs
    step();
    drive(1'b0, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
    wait_ready(1'b0, t0);
    step();
    drive(1'b0, 1'b0, 32'h47000000, 32'h46000000, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("hold_operands", {bus.fpu_n1, bus.fpu_n2, 31'd0, bus.fpu_sel},
          {32'h40000000, 32'h40000000, 32'd0});
    end
    wait_resp(1'b0, t0, 32'h40800000, 8, 1'b0);
    wait_idle();

    // unit keeps busy after done: stay in RELEASE, accept nothing
    std_t = 1'b0;
    hold = 1'b1;
    step();
    drive(1'b0, 1'b1, 32'h40400000, 32'h40400000, 1'b0);
    wait_ready(1'b0, t0);
    step();
    drop();
    wait_resp(1'b0, t0, 32'h40C00000, 8, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h40400000, 32'h3F800000, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("release_hold", {bus.fpu_start, bus.req1_ready, bus.arb_busy},
          3'b001);
    end
    step();
    hold = 1'b0;
    wait_ready(1'b1, t0);
    step();
    drop();
    wait_resp(1'b1, t0, 32'h40800000, 8, 1'b0);
    wait_idle();
    std_t = 1'b1;

    // random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      step();
      drive(1'b0, $urandom_range(0, 2) != 0, rnd_f(), rnd_f(),
            1'($urandom_range(0, 1)));
      drive(1'b1, $urandom_range(0, 2) != 0, rnd_f(), rnd_f(),
            1'($urandom_range(0, 1)));
    end
    step();
    drop();
    wait_idle();
    chk("scoreboard_empty", q.size(), 0);

    // reset during ISSUE, with a request pending
    step();
    drive(1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
    wait_ready(1'b0, t0);
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    step();
    chk_reset_outputs("held_reset");
    drop();
    rst_n = 1'b1;
    run_one(vt[0].port, vt[0].a, vt[0].b, vt[0].op, vt[0].res);

`ifdef FPU_ARB_TIMEOUT_EN
    // unit never finishes: abort response 17 cycles after ready
    std_t = 1'b0;
    hang = 1'b1;
    lat = 17;
    step();
    drive(1'b1, 1'b1, 32'h3F800000, 32'h40000000, 1'b0);
    wait_ready(1'b1, t0);
    step();
    drop();
    wait_resp(1'b1, t0, 32'd0, 17, 1'b1);
    wait_idle();
    rst_n = 1'b0;
    step();
    hang = 1'b0;
    lat = 8;
    rst_n = 1'b1;
    std_t = 1'b1;
    run_one(vt[1].port, vt[1].a, vt[1].b, vt[1].op, vt[1].res);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
